widget_motion_sched: RTL

- Frame-synchronous scheduler for on-screen widget motion.
- Replaces the free-running clock-divider pulse that steps widgets at arbitrary times. Each widget now advances position only at the start of vertical blanking, which prevents tearing.
- Sequences up to NUM_WIDGETS widget enable inputs, one per clock, every (frameDiv+1) frames.
- Supports run, pause and single-step under switch control. Sits between VGALLDriver's VBlank output and the widget instances' enable inputs.

---
 rtl/widget_motion_sched.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/widget_motion_sched.sv
// Frame-synchronous widget motion scheduler: on a due VBlank rising edge it
// issues one enable pulse slot per widget, then signals completion.
module widget_motion_sched #(
  parameter int NUM_WIDGETS = 4,
  parameter int FRAME_DIV_W = 4
) (
  input  logic                   CLK_100MHz,
  input  logic                   Reset,
  input  logic                   VBlank,
  input  logic [FRAME_DIV_W-1:0] frameDiv,
  input  logic                   run,
  input  logic                   stepReq,
  input  logic [NUM_WIDGETS-1:0] widgMask,
  output logic [NUM_WIDGETS-1:0] widgEn,
  output logic                   busy,
  output logic                   updateDone,
  output logic [15:0]            frameCount
);

  // idx must be able to hold NUM_WIDGETS itself, the "all slots issued" marker.
  localparam int IDX_W = $clog2(NUM_WIDGETS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e                 state_q,        state_d;
  logic                   vb_prev_q,      vb_prev_d;
  logic                   step_prev_q,    step_prev_d;
  logic                   step_pending_q, step_pending_d;
  logic [FRAME_DIV_W-1:0] div_cnt_q,      div_cnt_d;
  logic [NUM_WIDGETS-1:0] mask_q,         mask_d;
  logic [IDX_W-1:0]       idx_q,          idx_d;
  logic [NUM_WIDGETS-1:0] widg_en_q,      widg_en_d;
  logic                   busy_q,         busy_d;
  logic                   update_done_q,  update_done_d;
  logic [15:0]            frame_count_q,  frame_count_d;

  logic vb_edge;
  logic step_edge;
  logic due;
  logic start;

  always_comb begin
    vb_edge   = VBlank  & ~vb_prev_q;
    step_edge = stepReq & ~step_prev_q;
    // A lowered frameDiv can leave the counter above it; >= recovers at once.
    due       = vb_edge && (div_cnt_q >= frameDiv);
    start     = due && (run || step_pending_q) && (state_q == IDLE);
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d        = state_q;
    vb_prev_d      = VBlank;
    step_prev_d    = stepReq;
    step_pending_d = step_pending_q;
    div_cnt_d      = div_cnt_q;
    mask_d         = mask_q;
    idx_d          = idx_q;
    widg_en_d      = '0;
    busy_d         = busy_q;
    update_done_d  = 1'b0;
    frame_count_d  = frame_count_q;

    if (vb_edge) begin
      div_cnt_d = due ? '0 : div_cnt_q + FRAME_DIV_W'(1);
    end

    // A fresh step edge wins over the clear, so it is never lost.
    if (start && !run) begin
      step_pending_d = 1'b0;
    end
    if (step_edge) begin
      step_pending_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          // Slot 0 is issued on the start edge so widget 0 fires the very next cycle.
          mask_d       = widgMask;
          widg_en_d[0] = widgMask[0];
          idx_d        = IDX_W'(1);
          busy_d       = 1'b1;
          state_d      = ISSUE;
        end
      end

      ISSUE: begin
        if (idx_q == IDX_W'(NUM_WIDGETS)) begin
          update_done_d = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
          state_d       = DONE;
        end else begin
          for (int i = 0; i < NUM_WIDGETS; i++) begin
            if (idx_q == IDX_W'(i)) begin
              widg_en_d[i] = mask_q[i];
            end
          end
          idx_d = idx_q + IDX_W'(1);
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Edge history resets high so a level already asserted at release is not an edge.
  always_ff @(posedge CLK_100MHz or negedge Reset) begin
    if (!Reset) begin
      state_q        <= IDLE;
      vb_prev_q      <= 1'b1;
      step_prev_q    <= 1'b1;
      step_pending_q <= 1'b0;
      div_cnt_q      <= '0;
      mask_q         <= '0;
      idx_q          <= '0;
      widg_en_q      <= '0;
      busy_q         <= 1'b0;
      update_done_q  <= 1'b0;
      frame_count_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q        <= state_d;
      vb_prev_q      <= vb_prev_d;
      step_prev_q    <= step_prev_d;
      step_pending_q <= step_pending_d;
      div_cnt_q      <= div_cnt_d;
      mask_q         <= mask_d;
      idx_q          <= idx_d;
      widg_en_q      <= widg_en_d;
      busy_q         <= busy_d;
      update_done_q  <= update_done_d;
      frame_count_q  <= frame_count_d;
    end
  end

  always_ff @(posedge CLK_100MHz) begin
    assert ($onehot0(widg_en_q));
  end

  assign widgEn     = widg_en_q;
  assign busy       = busy_q;
  assign updateDone = update_done_q;
  assign frameCount = frame_count_q;

endmodule
